// File: rtl/bcd_display_formatter.sv
// bcd_display_formatter
// Turns a 32-bit display word into eight SSEG nibbles. It accepts unsigned or
// two's-complement input. The conversion is a sequential double-dabble that
// runs one iteration per clock. The result then gets leading-zero blanking,
// minus-sign placement and overflow detection.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; last result held on digits/neg/ovf
// SHIFT  | one double-dabble iteration per cycle, CONV_BITS iterations
// FORMAT | overflow test, blanking and sign placement; registers outputs
//
// Nibble codes on digits: 0-9 digit, 4'hA minus, 4'hF blank.

module bcd_display_formatter #(
    parameter int CONV_BITS     = 32,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        signed_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] digits,
    output logic        neg,
    output logic        ovf
);

    localparam int CNT_W = $clog2(CONV_BITS);

    localparam logic [31:0] DIGITS_RESET = 32'hFFFF_FFF0;
    localparam logic [31:0] DIGITS_OVF   = 32'hAAAA_AAAA;
    localparam logic [3:0]  NIB_MINUS    = 4'hA;
    localparam logic [3:0]  NIB_BLANK    = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             sign_q;
    logic [31:0]      mag_q;
    logic [39:0]      bcd_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             last_iter;
    logic             sign_in;
    logic [38:0]      bcd_adj;

    logic             ovf_calc;
    logic [2:0]       msd;
    logic [31:0]      fmt_digits;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (cnt_q == '0);
    assign sign_in   = signed_mode & value[31];
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start seen outside IDLE is dropped, not queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_iter) state_next = FORMAT;
            FORMAT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on each BCD digit before the shift.
    // The input is below 2^32, so the top digit never goes above 4. It
    // therefore never needs a correction, and its bit 3 stays clear.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 9; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        bcd_adj[38:36] = bcd_q[38:36];
    end

    // Operand capture and the double-dabble shift register.
    // The iteration counter counts down to zero for the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                sign_q <= sign_in;
                mag_q  <= sign_in ? (~value + 32'd1) : value;
                bcd_q  <= '0;
                cnt_q  <= CNT_W'(CONV_BITS - 1);
            end else if (state == SHIFT) begin
                {bcd_q, mag_q} <= {bcd_adj, mag_q, 1'b0};
                if (!last_iter) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    // Overflow test: a negative result uses one display position for the
    // minus sign, so it gets one digit less than a positive result.
    always_comb begin
        if (sign_q) begin
            ovf_calc = |bcd_q[39:28];
        end else begin
            ovf_calc = |bcd_q[39:32];
        end
    end

    // Find the most significant nonzero digit among the eight shown.
    // The result is 0 for a zero value, so digit 0 is always displayed.
    always_comb begin
        msd = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = 3'(i);
            end
        end
    end

    // Blanking and minus placement. With blanking on, the minus sits just
    // left of the most significant digit. With blanking off, it takes the
    // leftmost position instead. Position 7 is always a zero in that case,
    // because a negative result that does not overflow has seven digits or
    // fewer.
    always_comb begin
        fmt_digits = bcd_q[31:0];
        for (int i = 1; i < 8; i++) begin
            if (BLANK_LEADING) begin
                if (i > int'(msd)) begin
                    if (sign_q && (i == int'(msd) + 1)) begin
                        fmt_digits[4*i +: 4] = NIB_MINUS;
                    end else begin
                        fmt_digits[4*i +: 4] = NIB_BLANK;
                    end
                end
            end else begin
                if (sign_q && (i == 7)) begin
                    fmt_digits[4*i +: 4] = NIB_MINUS;
                end
            end
        end
    end

    // Output registers. They change only on the FORMAT edge, which keeps the
    // SSEG scan steady while the next conversion runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= DIGITS_RESET;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (state == FORMAT);
            if (state == FORMAT) begin
                ovf    <= ovf_calc;
                neg    <= sign_q;
                digits <= ovf_calc ? DIGITS_OVF : fmt_digits;
            end
        end
    end

endmodule
